// File: rtl/voxel_fetch_master_pkg.sv
// Shared types and defaults for the voxel/palette fetch master.
package voxel_fetch_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int WORD_BYTES      = 4;
  localparam int DEF_MAX_PENDING = 4;
  localparam int DEF_FIFO_DEPTH  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two; push when full is dropped unless a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/voxel_fetch_master.sv
// Avalon-MM pipelined read master streaming a word array into a valid/ready stream.
// Define VOXEL_FETCH_STATS_EN to add the stall_cycles waitrequest counter output.
module voxel_fetch_master
  import voxel_fetch_master_pkg::*;
#(
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] m1_address,
  output logic        m1_read,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  input  logic        m1_readdatavalid
`ifdef VOXEL_FETCH_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      base_q, base_d, count_q, count_d;
  logic [31:0]      issued_q, issued_d, consumed_q, consumed_d;
  logic [31:0]      pending_q, pending_d, addr_q, addr_d;
  logic [31:0]      fifo_next;
  logic             read_q, read_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, pop, issue, start_acc;

  assign start_acc = start && (state_q == IDLE);
  assign issue     = read_q && !m1_waitrequest;
  assign pop       = !fifo_empty && out_ready;

  // Every response is pushed unconditionally; the credit check keeps room for it.
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (m1_readdatavalid),
    .push_data_i (m1_readdata),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    read_d     = read_q;
    addr_d     = addr_q;
    issued_d   = issued_q + 32'(issue);
    consumed_d = consumed_q + 32'(pop);
    pending_d  = pending_q + 32'(issue) - 32'(m1_readdatavalid);
    fifo_next  = 32'(fifo_count) + 32'(m1_readdatavalid) - 32'(pop);
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          issued_d   = '0;
          consumed_d = '0;
          addr_d     = base_addr;
          read_d     = (word_count != '0);
          state_d    = (word_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // A stalled request holds address and read; otherwise re-arm against next-cycle credit.
        if (!(read_q && m1_waitrequest)) begin
          read_d = (issued_d != count_q) &&
                   (pending_d < 32'(MAX_PENDING)) &&
                   (pending_d + fifo_next < 32'(FIFO_DEPTH));
          addr_d = base_q + issued_d * 32'(WORD_BYTES);
        end
        if (issued_d == count_q) state_d = DRAIN;
      end
      DRAIN:   if (consumed_d == count_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      pending_q  <= '0;
      addr_q     <= '0;
      read_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      consumed_q <= consumed_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
    end
  end

  assign m1_read    = read_q;
  assign m1_address = addr_q;
  assign out_valid  = !fifo_empty;
  assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

`ifdef VOXEL_FETCH_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset || start_acc)                            stall_q <= '0;
    else if (m1_read && m1_waitrequest && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_voxel_fetch_master.sv
// Randomized self-checking bench for voxel_fetch_master with an in-bench Avalon memory model.
module tb_voxel_fetch_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] word_count = '0;
  logic        busy, done, out_valid, m1_read;
  logic [31:0] out_data, m1_address;
  logic        out_ready = 1'b0;
  logic        m1_waitrequest = 1'b0;
  logic [31:0] m1_readdata = '0;
  logic        m1_readdatavalid = 1'b0;
`ifdef VOXEL_FETCH_STATS_EN
  logic [31:0] stall_cycles;
`endif

  voxel_fetch_master dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .busy             (busy),
    .done             (done),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid)
`ifdef VOXEL_FETCH_STATS_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment knobs set by each test.
  int     wr_prob = 0, ready_prob = 100, lat_min = 2, lat_max = 2;
  longint ready_release_cyc = 0;
  int     stall_map[int];

  // Observation state maintained by the memory/consumer model.
  longint      cyc = 0, last_due = 0, done_cyc = 0, start_cyc = 0, last_pop_cyc = 0;
  logic [31:0] iss_addr[$], got[$], resp_addr[$];
  longint      resp_due[$];
  int          n_iss, n_resp, n_pop, done_cnt, hold_viol, valid_viol, stall_obs;
  int          peak_pend, peak_sum;
  logic        busy_at_done, prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] stall_snap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(negedge clock) begin
    int     pend, fifo;
    logic   wr;
    longint due;
    cyc++;
    if (reset) begin
      m1_waitrequest   = 1'b0;
      m1_readdatavalid = 1'b0;
      m1_readdata      = '0;
      resp_addr.delete();
      resp_due.delete();
      prev_stall = 1'b0;
    end else begin
      pend      = n_iss - n_resp;
      fifo      = n_resp - n_pop;
      peak_pend = max_i(peak_pend, pend);
      peak_sum  = max_i(peak_sum, pend + fifo);
      if (out_valid && fifo == 0) valid_viol++;
      if (prev_stall && (!m1_read || m1_address !== prev_addr)) hold_viol++;

      wr = 1'b0;
      if (m1_read) begin
        if (stall_map.exists(n_iss) && stall_map[n_iss] > 0) begin
          wr = 1'b1;
          stall_map[n_iss] = stall_map[n_iss] - 1;
        end else if ($urandom_range(99) < wr_prob) begin
          wr = 1'b1;
        end
      end
      m1_waitrequest = wr;
      prev_stall = m1_read && wr;
      prev_addr  = m1_address;
      if (m1_read && wr) stall_obs++;
      if (m1_read && !wr) begin
        iss_addr.push_back(m1_address);
        resp_addr.push_back(m1_address);
        due = cyc + longint'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        resp_due.push_back(due);
        n_iss++;
      end

      m1_readdatavalid = 1'b0;
      m1_readdata      = '0;
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
        m1_readdatavalid = 1'b1;
        m1_readdata      = mem_word(resp_addr.pop_front());
        void'(resp_due.pop_front());
        n_resp++;
      end

      out_ready = (cyc >= ready_release_cyc) && ($urandom_range(99) < ready_prob);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_pop_cyc = cyc;
        n_pop++;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (start) start_cyc = cyc;
    end
  end

  task automatic clear_obs();
    iss_addr.delete();
    got.delete();
    n_iss = 0; n_resp = 0; n_pop = 0; done_cnt = 0;
    hold_viol = 0; valid_viol = 0; stall_obs = 0;
    peak_pend = 0; peak_sum = 0; last_due = cyc;
  endtask

  // Runs one fetch and checks addresses, data order, done timing and credit limits.
  task automatic do_fetch(input logic [31:0] base, input int cnt, input string name);
    int bad_a, bad_d;
    clear_obs();
    @(posedge clock); #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    @(posedge clock); #1;
    start = 1'b0; base_addr = $urandom; word_count = $urandom;
`ifdef VOXEL_FETCH_STATS_EN
    stall_snap = stall_cycles;
`else
    stall_snap = '0;
`endif
    n_tests++;
    if (busy !== (cnt != 0)) begin
      n_fail++; $display("FAIL %s busy_after_start got=%0b exp=%0b", name, busy, cnt != 0);
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    end
    n_tests++;
    if (busy !== 1'b0 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_low got=%0b at_done=%0b exp=0", name, busy, busy_at_done);
    end
    n_tests++;
    if (iss_addr.size() != cnt || got.size() != cnt) begin
      n_fail++; $display("FAIL %s counts issued=%0d popped=%0d exp=%0d", name, iss_addr.size(), got.size(), cnt);
    end
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < cnt && i < iss_addr.size(); i++)
      if (iss_addr[i] !== base + 32'(4 * i)) bad_a++;
    for (int i = 0; i < cnt && i < got.size(); i++)
      if (got[i] !== mem_word(base + 32'(4 * i))) bad_d++;
    n_tests++;
    if (bad_a != 0 || bad_d != 0) begin
      n_fail++; $display("FAIL %s order bad_addr=%0d bad_data=%0d exp=0", name, bad_a, bad_d);
    end
    n_tests++;
    if (hold_viol != 0 || valid_viol != 0 || peak_pend > 4 || peak_sum > 8) begin
      n_fail++;
      $display("FAIL %s protocol hold=%0d early_valid=%0d peak_pend=%0d peak_sum=%0d exp 0/0/<=4/<=8",
               name, hold_viol, valid_viol, peak_pend, peak_sum);
    end
    if (cnt != 0) begin
      n_tests++;
      if (done_cyc != last_pop_cyc + 1) begin
        n_fail++; $display("FAIL %s done_timing got=%0d exp=%0d", name, done_cyc, last_pop_cyc + 1);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (busy !== 0 || done !== 0 || out_valid !== 0 || m1_read !== 0 ||
        m1_address !== 0 || out_data !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs busy=%0b done=%0b valid=%0b read=%0b addr=%h data=%h exp all 0",
               busy, done, out_valid, m1_read, m1_address, out_data);
    end
`ifdef VOXEL_FETCH_STATS_EN
    n_tests++;
    if (stall_cycles !== 0) begin
      n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    wr_prob = 0; ready_prob = 100; lat_min = 2; lat_max = 2; ready_release_cyc = 0;
    do_fetch(32'h0000_1000, 4, "basic");
  endtask

  task automatic test_zero_count();
    do_fetch(32'h0000_4000, 0, "zero");
    n_tests++;
    if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      n_fail++; $display("FAIL zero_done_delay got=%0d exp=1..2", done_cyc - start_cyc);
    end
  endtask

  task automatic test_waitrequest();
    stall_map.delete();
    stall_map[1] = 5;
    do_fetch(32'h0000_1000, 4, "waitreq");
    n_tests++;
    if (stall_obs != 5) begin
      n_fail++; $display("FAIL waitreq_stalled_cycles got=%0d exp=5", stall_obs);
    end
    stall_map.delete();
  endtask

  task automatic test_backpressure();
    lat_min = 5; lat_max = 8;
    ready_release_cyc = cyc + 80;
    do_fetch(32'h0000_8000, 20, "backpressure");
    n_tests++;
    if (peak_pend != 4 || peak_sum != 8) begin
      n_fail++; $display("FAIL backpressure_credit peak_pend=%0d peak_sum=%0d exp 4/8", peak_pend, peak_sum);
    end
    lat_min = 2; lat_max = 2; ready_release_cyc = 0;
  endtask

  task automatic test_reset_mid();
    clear_obs();
    lat_min = 3; lat_max = 3;
    @(posedge clock); #1;
    start = 1'b1; base_addr = 32'h0000_7000; word_count = 30;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    n_tests++;
    if (busy !== 0 || m1_read !== 0 || out_valid !== 0 || done !== 0) begin
      n_fail++; $display("FAIL reset_mid busy=%0b read=%0b valid=%0b done=%0b exp all 0",
                         busy, m1_read, out_valid, done);
    end
    reset = 1'b0;
    lat_min = 2; lat_max = 2;
    do_fetch(32'h0000_2000, 2, "restart");
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int it = 0; it < 6; it++) begin
      wr_prob = $urandom_range(40); ready_prob = $urandom_range(100, 30);
      lat_min = $urandom_range(3, 1); lat_max = lat_min + $urandom_range(4);
      base = (it == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      do_fetch(base, $urandom_range(24, 1), $sformatf("random%0d", it));
    end
    wr_prob = 0; ready_prob = 100; lat_min = 2; lat_max = 2;
  endtask

`ifdef VOXEL_FETCH_STATS_EN
  task automatic test_stats();
    stall_map.delete();
    stall_map[1] = 4;
    stall_map[3] = 3;
    do_fetch(32'h0000_5000, 5, "stats");
    n_tests++;
    if (stall_cycles !== 32'd7) begin
      n_fail++; $display("FAIL stats_count got=%0d exp=7", stall_cycles);
    end
    stall_map.delete();
    do_fetch(32'h0000_3000, 2, "stats_clear");
    n_tests++;
    if (stall_snap !== 32'd0 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL stats_clear after_start=%0d end=%0d exp=0", stall_snap, stall_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_waitrequest();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef VOXEL_FETCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
